// File: rtl/alu_driver.sv
// alu_driver: handshaked sequencer around a combinational ALU.
// It takes one request, drives and holds the ALU inputs for SETTLE_CYCLES edges,
// captures the ALU result, and presents it until the consumer accepts it.
// op_count tracks completed responses, wrapping modulo 2^COUNT_WIDTH.
module alu_driver #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned OP_WIDTH      = 4,
  parameter int unsigned SETTLE_CYCLES = 1,  // legal range 1..15
  parameter int unsigned COUNT_WIDTH   = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  // request channel
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [DATA_WIDTH-1:0]  req_a,
  input  logic [DATA_WIDTH-1:0]  req_b,
  input  logic [OP_WIDTH-1:0]    req_op,
  // ALU side
  output logic [DATA_WIDTH-1:0]  alu_a,
  output logic [DATA_WIDTH-1:0]  alu_b,
  output logic [OP_WIDTH-1:0]    alu_op,
  input  logic [DATA_WIDTH-1:0]  alu_result,
  // response channel
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA_WIDTH-1:0]  rsp_result,
  output logic [OP_WIDTH-1:0]    rsp_op,
  output logic [COUNT_WIDTH-1:0] op_count
);

  // Four bits cover the full 1..15 settle range.
  localparam int unsigned CntWidth = 4;
  localparam logic [CntWidth-1:0] SettleLoad = CntWidth'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StResp
  } state_e;

  state_e              state;
  logic [CntWidth-1:0] settle_cnt;

  // Single-process FSM; handshake flags are registered alongside the state so
  // req_ready/rsp_valid come straight from flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= StIdle;
      settle_cnt <= '0;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      rsp_result <= '0;
      rsp_op     <= '0;
      op_count   <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (req_valid) begin
            alu_a      <= req_a;
            alu_b      <= req_b;
            alu_op     <= req_op;
            rsp_op     <= req_op;
            settle_cnt <= SettleLoad;
            req_ready  <= 1'b0;
            state      <= StSettle;
          end
        end
        StSettle: begin
          // Counter reaching zero means the ALU inputs have been stable long enough.
          if (settle_cnt == '0) begin
            rsp_result <= alu_result;
            rsp_valid  <= 1'b1;
            state      <= StResp;
          end else begin
            settle_cnt <= settle_cnt - CntWidth'(1);
          end
        end
        StResp: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            op_count  <= op_count + COUNT_WIDTH'(1);
            state     <= StIdle;
          end
        end
        default: begin
          state     <= StIdle;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/alu_driver.md
# alu_driver

Sequencing front end for the combinational ALU: accepts one operation request (two operands plus opcode) over a valid/ready handshake, drives and holds the ALU operand/opcode inputs for a programmable settle time, samples the ALU result, and returns it over a second valid/ready handshake. It sits between the datapath controller and the ALU and turns the ALU into a handshaked, one-operation-at-a-time resource. It also keeps a running count of completed operations.

## Interface

- DATA_WIDTH, 8: operand and result width.
- OP_WIDTH, 4: opcode width.
- SETTLE_CYCLES, 1: clock edges ALU inputs are held before the result is sampled; legal range 1–15.
- COUNT_WIDTH, 8: width of the completed-operation counter.

Clocking and reset: one clock; reset is synchronous and active-high.

- clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_a  in  DATA_WIDTH  operand A.
- req_b  in  DATA_WIDTH  operand B.
- req_op  in  OP_WIDTH  ALU opcode.
- alu_a  out  DATA_WIDTH  registered operand A to ALU.
- alu_b  out  DATA_WIDTH  registered operand B to ALU.
- alu_op  out  OP_WIDTH  registered opcode to ALU.
- alu_result  in  DATA_WIDTH  combinational ALU result.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_result  out  DATA_WIDTH  captured ALU result.
- rsp_op  out  OP_WIDTH  opcode that produced rsp_result.
- op_count  out  COUNT_WIDTH  completed responses, modulo 2^COUNT_WIDTH.

## Operation

- States: IDLE, SETTLE, RESP.
- IDLE: req_ready=1, rsp_valid=0. When req_valid=1 at an edge, register req_a/req_b/req_op into alu_a/alu_b/alu_op and rsp_op. Load settle counter with SETTLE_CYCLES-1. Go to SETTLE.
- SETTLE: req_ready=0. When the counter is 0 at an edge, capture alu_result into rsp_result and go to RESP. Otherwise decrement the counter.
- RESP: rsp_valid=1, req_ready=0. When rsp_ready=1 at an edge, increment op_count (wraps to 0) and go to IDLE.
- Requests are not accepted outside IDLE. Request inputs are ignored when req_ready=0.
- alu_a/alu_b/alu_op keep the last operands after the response completes. They are not cleared and are not changed until the next accept.
- rsp_result and rsp_op are stable while rsp_valid=1 and rsp_ready=0. They keep their values after the handshake.
- A rsp_ready asserted outside RESP has no effect.

## Timing

- Reset: state IDLE. req_ready=1; rsp_valid=0; alu_a, alu_b, alu_op, rsp_result, rsp_op, op_count all 0; settle counter 0.
- Accept at edge E0: alu_* carry the new operands after E0.
- Result is sampled at edge E0+SETTLE_CYCLES. rsp_valid rises after that edge. Latency from accept to rsp_valid is SETTLE_CYCLES cycles.
- When rsp_ready is already high, the response handshake completes at edge E0+SETTLE_CYCLES+1 and req_ready is high after it. The earliest next accept is edge E0+SETTLE_CYCLES+2. Peak throughput is one op per SETTLE_CYCLES+2 cycles.
- rsp_ready low holds RESP indefinitely with no loss of data.
- Reset asserted in any state overrides everything at that edge. An in-flight operation is dropped with no response, and op_count returns to 0.
- op_count at 2^COUNT_WIDTH-1 followed by a completed response gives 0.

## Test plan

- Bench ALU model: op0 = a+b, op1 = a−b, others = a&b, all modulo 2^DATA_WIDTH. SETTLE_CYCLES=1, rsp_ready=1.
  - a=2, b=3, op=0 -> rsp_result=5, rsp_op=0, rsp_valid high exactly 1 cycle after the accept edge, op_count=1.
  - a=2, b=3, op=1 -> rsp_result=8'hFF, rsp_op=1.
- Backpressure: hold rsp_ready=0 for 10 cycles after a=7, b=1, op=0 -> rsp_valid stays 1 and rsp_result stays 8 for all 10 cycles. req_ready stays 0 and a second request held on req_* is not taken. After rsp_ready=1, the second request is accepted on the cycle after the handshake.
- SETTLE_CYCLES=4: a=9, b=4, op=2. Accept at edge E0 -> alu_a=9 from E0, rsp_valid rises after E0+4, rsp_result=0.
- Reset mid-SETTLE (SETTLE_CYCLES=4, reset at E0+2) -> next cycle: req_ready=1, rsp_valid=0, all outputs 0, no response ever produced for that request.
- Counter wrap: 256 back-to-back ops with COUNT_WIDTH=8 -> op_count reads 255 after op 255 and 0 after op 256. Every result matches the model.
